// File: rtl/conf_int_mul_pipe.sv
// Pipelined signed multiplier with per-op accurate/approximate operand precision,
// valid/ready streaming, a saturating output slice and per-mode delivered-op counters.
module conf_int_mul_pipe #(
  parameter int DATA_PATH_BITWIDTH = 24,
  parameter int APX_BITS           = 8,
  parameter int OUT_SHIFT          = 8,
  parameter int OUT_BITWIDTH       = 32,
  parameter int PIPE_STAGES        = 2,
  parameter int SAT_EN             = 1,
  parameter int CNT_BITWIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          apx_en,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_BITWIDTH-1:0]       P,
  output logic                          out_apx,
  output logic [CNT_BITWIDTH-1:0]       acc_cnt,
  output logic [CNT_BITWIDTH-1:0]       apx_cnt
);

  localparam int DW    = DATA_PATH_BITWIDTH;
  localparam int PW    = 2 * DW;
  localparam int NPROD = PIPE_STAGES - 2;
  localparam int TOP   = OUT_SHIFT + OUT_BITWIDTH;

  localparam logic [DW-1:0]           APX_MASK = {DW{1'b1}} << APX_BITS;
  localparam logic [OUT_BITWIDTH-1:0] SAT_MAX  = {1'b0, {(OUT_BITWIDTH-1){1'b1}}};
  localparam logic [OUT_BITWIDTH-1:0] SAT_MIN  = {1'b1, {(OUT_BITWIDTH-1){1'b0}}};
  localparam logic [CNT_BITWIDTH-1:0] CNT_ONE  = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};

  logic          advance;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          s1_valid;
  logic          s1_apx;
  logic [PW-1:0] prod_comb;
  logic [PW-1:0] prod_fin;
  logic          vld_fin;
  logic          tag_fin;
  logic [OUT_BITWIDTH-1:0] raw_slice;
  logic [OUT_BITWIDTH-1:0] sat_val;
  logic [OUT_BITWIDTH-1:0] p_next;
  logic          ovf;

  // The whole pipe moves in lockstep; bubbles are kept rather than collapsed.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_valid <= 1'b0;
      s1_apx   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_apx <= apx_en;
        a_q    <= apx_en ? (a & APX_MASK) : a;
        b_q    <= apx_en ? (b & APX_MASK) : b;
      end
    end
  end

  // Sign-extend to full product width so the truncated product is exact.
  assign prod_comb = $signed({{DW{a_q[DW-1]}}, a_q}) * $signed({{DW{b_q[DW-1]}}, b_q});

  generate
    if (NPROD == 0) begin : g_no_prod_regs
      assign prod_fin = prod_comb;
      assign vld_fin  = s1_valid;
      assign tag_fin  = s1_apx;
    end else begin : g_prod_regs
      logic [PW-1:0]    prod_q [NPROD];
      logic [NPROD-1:0] pv_q;
      logic [NPROD-1:0] pt_q;

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          for (int i = 0; i < NPROD; i++) prod_q[i] <= '0;
          pv_q <= '0;
          pt_q <= '0;
        end else if (advance) begin
          prod_q[0] <= prod_comb;
          pv_q[0]   <= s1_valid;
          pt_q[0]   <= s1_apx;
          for (int i = 1; i < NPROD; i++) begin
            prod_q[i] <= prod_q[i-1];
            pv_q[i]   <= pv_q[i-1];
            pt_q[i]   <= pt_q[i-1];
          end
        end
      end

      assign prod_fin = prod_q[NPROD-1];
      assign vld_fin  = pv_q[NPROD-1];
      assign tag_fin  = pt_q[NPROD-1];
    end
  endgenerate

  assign raw_slice = prod_fin[TOP-1:OUT_SHIFT];
  assign sat_val   = prod_fin[PW-1] ? SAT_MIN : SAT_MAX;

  // Overflow: bits above the slice disagree with the slice MSB.
  generate
    if (SAT_EN != 0 && TOP < PW) begin : g_sat
      logic [PW-TOP:0] upper;
      assign upper = prod_fin[PW-1:TOP-1];
      assign ovf   = ~((&upper) | ~(|upper));
    end else begin : g_no_sat
      assign ovf = 1'b0;
      if (TOP < PW) begin : g_upper
        logic unused_upper;
        assign unused_upper = ^prod_fin[PW-1:TOP];
      end
    end
    if (OUT_SHIFT > 0) begin : g_low
      logic unused_low_bits;
      assign unused_low_bits = ^prod_fin[OUT_SHIFT-1:0];
    end
  endgenerate

  assign p_next = ovf ? sat_val : raw_slice;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid <= 1'b0;
      out_apx   <= 1'b0;
      P         <= '0;
    end else if (advance) begin
      out_valid <= vld_fin;
      if (vld_fin) begin
        P       <= p_next;
        out_apx <= tag_fin;
      end
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc_cnt <= '0;
      apx_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_apx) begin
        if (apx_cnt != '1) apx_cnt <= apx_cnt + CNT_ONE;
      end else begin
        if (acc_cnt != '1) acc_cnt <= acc_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_conf_int_mul_pipe.sv
// Self-checking bench: directed vector table, stall/reset sequences, counter saturation
// and a randomized stream checked against an arithmetic reference model.
module tb_conf_int_mul_pipe;

  localparam int DW  = 24;
  localparam int OB  = 32;
  localparam int APX = 8;

  logic          clk = 1'b0;
  logic          rstN;
  logic          in_valid;
  logic          apx_en;
  logic          out_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;

  logic          s_in_ready, s_out_valid, s_out_apx;
  logic [OB-1:0] s_P;
  logic [15:0]   s_acc, s_apx;
  logic          n_in_ready, n_out_valid, n_out_apx;
  logic [OB-1:0] n_P;
  logic [3:0]    n_acc, n_apx;

  always #5 clk = ~clk;

  conf_int_mul_pipe #(
    .DATA_PATH_BITWIDTH(DW), .APX_BITS(APX), .OUT_SHIFT(8), .OUT_BITWIDTH(OB),
    .PIPE_STAGES(2), .SAT_EN(1), .CNT_BITWIDTH(16)
  ) dut_s (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(s_in_ready), .apx_en(apx_en),
    .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready), .P(s_P),
    .out_apx(s_out_apx), .acc_cnt(s_acc), .apx_cnt(s_apx)
  );

  conf_int_mul_pipe #(
    .DATA_PATH_BITWIDTH(DW), .APX_BITS(APX), .OUT_SHIFT(8), .OUT_BITWIDTH(OB),
    .PIPE_STAGES(2), .SAT_EN(0), .CNT_BITWIDTH(4)
  ) dut_n (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(n_in_ready), .apx_en(apx_en),
    .a(a), .b(b), .out_valid(n_out_valid), .out_ready(out_ready), .P(n_P),
    .out_apx(n_out_apx), .acc_cnt(n_acc), .apx_cnt(n_apx)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          m;
    logic [31:0]   ps;
    logic [31:0]   pn;
  } vec_t;

  typedef struct {
    logic [31:0] ps;
    logic [31:0] pn;
    logic        m;
  } res_t;

  res_t scoreboard[$];
  int   nCompared = 0;
  int   nMismatched = 0;
  int   accExp, apxExp, accExpN, apxExpN;
  logic curApx;

  // Reference: clear low bits in approximate mode, multiply, floor-shift, clamp or wrap.
  function automatic logic [31:0] refP(input logic [DW-1:0] aa, input logic [DW-1:0] bb,
                                       input logic m, input bit sat);
    logic [DW-1:0] ma, mb;
    longint sa, sb2, pr, sl;
    ma = aa;
    mb = bb;
    if (m) begin
      ma = (ma >> APX) << APX;
      mb = (mb >> APX) << APX;
    end
    sa  = longint'($signed(ma));
    sb2 = longint'($signed(mb));
    pr  = sa * sb2;
    sl  = pr >>> 8;
    if (sat && sl > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (sat && sl < -64'sh80000000) return 32'h80000000;
    return sl[31:0];
  endfunction

  function automatic logic [DW-1:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      2:       return 24'($urandom_range(0, 1023));
      3:       return 24'h000000 - 24'($urandom_range(1, 1023));
      default: return 24'($urandom());
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] aa, input logic [DW-1:0] bb,
                               input logic m, input logic rdy);
    in_valid  = v;
    a         = aa;
    b         = bb;
    apx_en    = m;
    out_ready = rdy;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    #1;
    scoreboard.delete();
    accExp = 0; apxExp = 0; accExpN = 0; apxExpN = 0;
  endtask

  // Per-cycle model step for the random stream; called after inputs settle, before the edge.
  task automatic sampleAndModel();
    logic expRdy;
    res_t r;
    expRdy = !s_out_valid || out_ready;
    checkOutput("in_ready", s_in_ready, expRdy);
    checkOutput("in_ready_n", n_in_ready, expRdy);
    checkOutput("out_valid_n", n_out_valid, s_out_valid);
    if (s_out_valid) begin
      if (scoreboard.size() == 0) begin
        checkOutput("spurious_out_valid", s_out_valid, 1'b0);
      end else begin
        r = scoreboard[0];
        checkOutput("rand_P_sat", s_P, r.ps);
        checkOutput("rand_P_nosat", n_P, r.pn);
        checkOutput("rand_out_apx", s_out_apx, r.m);
        if (out_ready) begin
          void'(scoreboard.pop_front());
          if (r.m) begin
            apxExp++;
            if (apxExpN < 15) apxExpN++;
          end else begin
            accExp++;
            if (accExpN < 15) accExpN++;
          end
        end
      end
    end
    if (in_valid && expRdy) begin
      r.ps = refP(a, b, apx_en, 1'b1);
      r.pn = refP(a, b, apx_en, 1'b0);
      r.m  = apx_en;
      scoreboard.push_back(r);
      curApx = ~curApx;
    end
  endtask

  vec_t vecs[7];
  vec_t ops[4];
  logic [DW-1:0] ra, rb;
  logic [31:0] rC;
  int accepted, cycles, tAcc, tApx;

  initial begin
    vecs = '{
      '{24'h0003FF, 24'h0002FF, 1'b0, 32'h00000BF9, 32'h00000BF9},
      '{24'h0003FF, 24'h0002FF, 1'b1, 32'h00000600, 32'h00000600},
      '{24'hFFFF00, 24'h000100, 1'b0, 32'hFFFFFF00, 32'hFFFFFF00},
      '{24'h7FFFFF, 24'h7FFFFF, 1'b0, 32'h7FFFFFFF, 32'hFFFF0000},
      '{24'hFFFF80, 24'h000301, 1'b1, 32'hFFFFFD00, 32'hFFFFFD00},
      '{24'h800000, 24'h7FFFFF, 1'b0, 32'h80000000, 32'h00008000},
      '{24'h800000, 24'h800000, 1'b0, 32'h7FFFFFFF, 32'h00000000}
    };
    ops = '{
      '{24'h001234, 24'h000567, 1'b0, 32'h0, 32'h0},
      '{24'hFF8765, 24'h0004F1, 1'b1, 32'h0, 32'h0},
      '{24'h7ABCDE, 24'hFFFF12, 1'b0, 32'h0, 32'h0},
      '{24'h0F0F0F, 24'h7FFFFF, 1'b1, 32'h0, 32'h0}
    };
    for (int i = 0; i < 4; i++) begin
      ops[i].ps = refP(ops[i].a, ops[i].b, ops[i].m, 1'b1);
      ops[i].pn = refP(ops[i].a, ops[i].b, ops[i].m, 1'b0);
    end

    // Asynchronous reset takes effect without a clock edge.
    in_valid = 1'b0; apx_en = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    rstN = 1'b1;
    #2 rstN = 1'b0;
    #1;
    checkOutput("reset_out_valid", s_out_valid, 1'b0);
    checkOutput("reset_P", s_P, 32'h0);
    checkOutput("reset_acc_cnt", s_acc, 16'h0);
    checkOutput("reset_apx_cnt", s_apx, 16'h0);
    checkOutput("reset_out_valid_n", n_out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    #1;
    checkOutput("reset_in_ready", s_in_ready, 1'b1);

    // Directed vector table: one op at a time, two-cycle latency.
    tAcc = 0; tApx = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].m, 1'b1);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d_not_early", i), s_out_valid, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), s_out_valid, 1'b1);
      checkOutput($sformatf("vec%0d_P_sat", i), s_P, vecs[i].ps);
      checkOutput($sformatf("vec%0d_P_nosat", i), n_P, vecs[i].pn);
      checkOutput($sformatf("vec%0d_out_apx", i), s_out_apx, vecs[i].m);
      if (vecs[i].m) tApx++; else tAcc++;
    end
    tick();
    checkOutput("vec_acc_cnt", s_acc, tAcc);
    checkOutput("vec_apx_cnt", s_apx, tApx);
    checkOutput("vec_out_valid_drained", s_out_valid, 1'b0);

    // Back-to-back stream stalled by the sink for three cycles.
    doReset();
    applyStimulus(1'b1, ops[0].a, ops[0].b, ops[0].m, 1'b1);
    tick();
    applyStimulus(1'b1, ops[1].a, ops[1].b, ops[1].m, 1'b1);
    tick();
    applyStimulus(1'b1, ops[2].a, ops[2].b, ops[2].m, 1'b0);
    checkOutput("stall_in_ready", s_in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall%0d_valid", i), s_out_valid, 1'b1);
      checkOutput($sformatf("stall%0d_P_held", i), s_P, ops[0].ps);
      checkOutput($sformatf("stall%0d_in_ready", i), s_in_ready, 1'b0);
    end
    applyStimulus(1'b1, ops[2].a, ops[2].b, ops[2].m, 1'b1);
    checkOutput("release_in_ready", s_in_ready, 1'b1);
    tick();
    checkOutput("order_P1", s_P, ops[1].ps);
    checkOutput("order_apx1", s_out_apx, ops[1].m);
    applyStimulus(1'b1, ops[3].a, ops[3].b, ops[3].m, 1'b1);
    tick();
    checkOutput("order_P2", s_P, ops[2].ps);
    checkOutput("order_P2_nosat", n_P, ops[2].pn);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    checkOutput("order_P3", s_P, ops[3].ps);
    checkOutput("order_apx3", s_out_apx, ops[3].m);
    tick();
    checkOutput("order_drained", s_out_valid, 1'b0);
    checkOutput("order_acc_cnt", s_acc, 16'd2);
    checkOutput("order_apx_cnt", s_apx, 16'd2);

    // Reset pulse with two ops in flight, then a fresh op.
    applyStimulus(1'b1, ops[0].a, ops[0].b, ops[0].m, 1'b1);
    tick();
    applyStimulus(1'b1, ops[1].a, ops[1].b, ops[1].m, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("inflight_valid", s_out_valid, 1'b1);
    rstN = 1'b0;
    #1;
    checkOutput("midrst_out_valid", s_out_valid, 1'b0);
    checkOutput("midrst_acc_cnt", s_acc, 16'h0);
    checkOutput("midrst_apx_cnt", s_apx, 16'h0);
    checkOutput("midrst_P", s_P, 32'h0);
    @(posedge clk);
    #1 rstN = 1'b1;
    tick();
    checkOutput("midrst_discarded", s_out_valid, 1'b0);
    rC = refP(24'hFFF123, 24'h00ABCD, 1'b0, 1'b1);
    applyStimulus(1'b1, 24'hFFF123, 24'h00ABCD, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("postrst_not_early", s_out_valid, 1'b0);
    tick();
    checkOutput("postrst_valid", s_out_valid, 1'b1);
    checkOutput("postrst_P", s_P, rC);

    // Counter saturation on the 4-bit instance.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, randOperand(), randOperand(), 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("cnt4_saturated", n_acc, 4'hF);
    checkOutput("cnt16_count", s_acc, 16'd16);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, randOperand(), randOperand(), 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("cnt4_holds", n_acc, 4'hF);
    checkOutput("cnt4_apx_zero", n_apx, 4'h0);
    checkOutput("cnt16_count2", s_acc, 16'd18);

    // Random stream with alternating mode and random back-pressure.
    doReset();
    curApx = 1'b0;
    accepted = 0;
    cycles = 0;
    while (accepted < 1000 && cycles < 20000) begin
      ra = randOperand();
      rb = randOperand();
      applyStimulus($urandom_range(0, 3) != 0, ra, rb, curApx, $urandom_range(0, 9) < 7);
      if (in_valid && (!s_out_valid || out_ready)) accepted++;
      sampleAndModel();
      tick();
      cycles++;
    end
    checkOutput("random_accepted", accepted, 1000);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      if (scoreboard.size() == 0 && !s_out_valid) break;
      sampleAndModel();
      tick();
    end
    checkOutput("random_drained", scoreboard.size(), 0);
    checkOutput("random_acc_cnt", s_acc, accExp);
    checkOutput("random_apx_cnt", s_apx, apxExp);
    checkOutput("random_acc_cnt_n", n_acc, accExpN);
    checkOutput("random_apx_cnt_n", n_apx, apxExpN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
